ah_pl2ddr_mc_cmd_fsm: RTL
=========================

// Module: ah_pl2ddr_mc_cmd_fsm
// PURPOSE
//  Multi-channel command/transfer sequencer for the PL-to-DDR path. It generalises the single-channel command FSM to NUM_CH sampling channels.
//  Each channel has its own BRAM fill level, DDR window, address offset and enable. A round-robin arbiter grants one AXI burst at a time.
//  Sits between the AXI-Lite command registers, the per-channel sample buffers and the shared AXI-full master.
// PARAMETERS
//  NUM_CH      4    number of channels (1..16); channel index is CH_W=$clog2(NUM_CH) bits, min 1
//  LVL_W       10   width of each per-channel fill-level field
//  BURST_MAX   256  max beats per burst (<=256); also the auto-trigger threshold
//  RESET_WAIT  0    cycles spent in WAIT after reset-type commands (0..31)
// PORTS
//  clk             in   1           system clock
//  rst             in   1           synchronous active-high reset
//  in_cmd_data     in   32          [31:28] channel, [15:0] opcode
//  in_cmd_en       in   1           command strobe
//  in_ddr_low      in   32*NUM_CH   per-channel window base (byte addr, 4-aligned)
//  in_ddr_high     in   32*NUM_CH   per-channel window end (exclusive)
//  in_level        in   LVL_W*NUM_CH  words buffered per channel
//  in_transfer_en  in   1           global permission to start bursts
//  in_axi_done     in   1           burst complete pulse
//  in_axi_error    in   1           AXI error level
//  out_axi_init    out  1           one-cycle burst start pulse
//  out_axi_addr    out  32          burst start byte address
//  out_axi_len     out  9           burst beats (1..BURST_MAX)
//  out_axi_ch      out  CH_W        granted channel (selects buffer read mux)
//  out_enable      out  NUM_CH      per-channel sampling enable
//  out_rst_data    out  NUM_CH      per-channel buffer reset pulse
//  out_busy        out  1           high from ARB grant to end of INTR
//  out_cmd_processed out 32         last latched command
//  out_status      out  8           b0 out-of-memory, b1 AXI fail, b7 bad channel
//  out_state       out  4           FSM state code
//  intr_sent, intr_ack, intr_error  out 1 each  one-cycle interrupt pulses
// BEHAVIOUR
//  Reset:
//   - All outputs 0; all offsets, enables, force/wrap/intr-mask bits 0; state IDLE.
//   - Reset mid-burst abandons the burst; no out_axi_init is issued afterwards.
//  Command capture:
//   - in_cmd_en latches the command when no command is pending; strobes while one is pending are dropped.
//   - Pending clears on the ACK cycle.
//  States: IDLE=0 ACK=1 EXEC=2 WAIT=3 ARB=4 CALC=5 START=6 WAIT_TX=7 INTR=8 ERROR=9
//   - IDLE priority: pending cmd -> ACK; else in_axi_error|err_flag -> ERROR; else in_transfer_en & any request -> ARB.
//   - Channel request = enable & (level>=BURST_MAX | (force & level>0)).
//   - ACK: intr_ack pulses if the ack mask is set -> EXEC.
//   - EXEC: channel field >= NUM_CH sets status b7 and executes nothing -> IDLE.
//   - Opcodes:
//     - 0001 RST: everything, all out_rst_data pulse -> WAIT.
//     - 0002 RST_ADDR: ch offset=0 -> WAIT.
//     - 0004 RST_DATA: ch out_rst_data pulse, force clear -> WAIT.
//     - 0020/0021 disable/enable ch.
//     - 0101 FORCE_TX: set ch force.
//     - 0040/0041 wrap off/on for ch.
//     - 1010/1011 sent-intr mask, 1080/1081 ack-intr mask, 1040/1041 error-intr mask.
//     - Unknown opcodes are ignored.
//     - All opcodes other than those ending in WAIT -> IDLE.
//   - WAIT: count RESET_WAIT down -> IDLE; out_rst_data is high only during the first WAIT cycle.
//   - ARB: grant the first requester after last_grant (round-robin, wraps NUM_CH-1->0) -> CALC.
//  Burst calculation (CALC):
//   - room = (high - low - offset)>>2; len = min(level, BURST_MAX, room); addr = low + offset.
//   - room==0 & wrap: offset<=0, stay in CALC one more cycle.
//   - room==0 & !wrap: status b0, err_flag -> ERROR.
//   - Otherwise -> START.
//  Transfer:
//   - START: out_axi_init=1 for exactly one cycle; addr/len/ch stay stable until WAIT_TX exits.
//   - WAIT_TX: on in_axi_done, offset += len<<2. The force bit clears when level-len==0, otherwise it is kept so the next ARB round continues. Then -> INTR.
//   - WAIT_TX: in_axi_error -> ERROR without updating the offset.
//   - INTR: intr_sent pulses if masked-on -> IDLE.
//  Error handling:
//   - ERROR: status b1 follows in_axi_error. On entry, intr_error pulses once if masked-on.
//   - ERROR is left only by a command (-> ACK) or, once the AXI error is clear and err_flag=0, -> IDLE.
//   - err_flag clears only via RST.
//  Arithmetic:
//   - Offsets are 32-bit unsigned; high<=low+offset means room=0.
//   - Level compares are unsigned LVL_W-bit.
// TESTING
//  1. NUM_CH=4, ch1 enabled, level1=256, window 0x1000..0x2000 -> init pulse, addr 0x1000, len 256, ch 1; after done, offset 0x400.
//  2. ch0 and ch2 both level 300 -> grants alternate 0,2,0,2; no channel is granted twice in a row.
//  3. ch3 FORCE_TX, level 5 -> len 5; force clears after done; a second FORCE with level 0 starts no burst.
//  4. Window 0x0..0x40, level 256 -> len 16; next request: wrap off -> status 0x01 + intr_error, wrap on -> addr back to low.
//  5. in_axi_error during WAIT_TX -> ERROR, status 0x02, offset unchanged; RST cmd -> IDLE, status 0.
//  6. Command with channel 9 while NUM_CH=4 -> status b7 set, no enable change; cmd strobe during ACK is dropped.

Source files
------------

// File: rtl/ah_pl2ddr_mc_cmd_fsm.sv
// ah_pl2ddr_mc_cmd_fsm
//   Multi-channel command/transfer sequencer for the PL-to-DDR path. Decodes
//   AXI-Lite commands into per-channel control bits, arbitrates round-robin
//   between channels whose sample buffers need draining, and drives one AXI
//   burst at a time on the shared AXI-full master.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_cmd_data/en      command word ([31:28] channel, [15:0] opcode) + strobe
//   in_ddr_low/high     per-channel DDR window [low, high) in bytes, 32b each
//   in_level            per-channel buffered word count, LVL_W bits each
//   in_transfer_en      global permission to start bursts
//   in_axi_done/error   burst-complete pulse / AXI error level
//   out_axi_init        one-cycle burst start pulse
//   out_axi_addr/len/ch burst start address, beat count, granted channel
//   out_enable          per-channel sampling enable
//   out_rst_data        per-channel buffer reset pulse (first WAIT cycle)
//   out_busy            high from ARB through INTR
//   out_cmd_processed   last latched command word
//   out_status          b0 out-of-memory, b1 AXI fail, b7 bad channel
//   out_state           FSM state code (debug)
//   intr_sent/ack/error one-cycle interrupt pulses, each gated by its mask
//
// Handshake: a command is accepted on any cycle with in_cmd_en=1 while no
// command is pending; it stays pending until its ACK cycle, and strobes seen
// while pending are dropped. A burst is offered with a single out_axi_init
// pulse; addr/len/ch then hold until in_axi_done or in_axi_error ends it.
module ah_pl2ddr_mc_cmd_fsm #(
  parameter int NUM_CH     = 4,
  parameter int LVL_W      = 10,
  parameter int BURST_MAX  = 256,
  parameter int RESET_WAIT = 0,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             in_cmd_data,
  input  logic                    in_cmd_en,
  input  logic [32*NUM_CH-1:0]    in_ddr_low,
  input  logic [32*NUM_CH-1:0]    in_ddr_high,
  input  logic [LVL_W*NUM_CH-1:0] in_level,
  input  logic                    in_transfer_en,
  input  logic                    in_axi_done,
  input  logic                    in_axi_error,
  output logic                    out_axi_init,
  output logic [31:0]             out_axi_addr,
  output logic [8:0]              out_axi_len,
  output logic [CH_W-1:0]         out_axi_ch,
  output logic [NUM_CH-1:0]       out_enable,
  output logic [NUM_CH-1:0]       out_rst_data,
  output logic                    out_busy,
  output logic [31:0]             out_cmd_processed,
  output logic [7:0]              out_status,
  output logic [3:0]              out_state,
  output logic                    intr_sent,
  output logic                    intr_ack,
  output logic                    intr_error
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ACK     = 4'd1,
    S_EXEC    = 4'd2,
    S_WAIT    = 4'd3,
    S_ARB     = 4'd4,
    S_CALC    = 4'd5,
    S_START   = 4'd6,
    S_WAIT_TX = 4'd7,
    S_INTR    = 4'd8,
    S_ERROR   = 4'd9
  } state_t;

  state_t state, state_prev, state_next;

  // Command register
  logic        cmd_pending;
  logic [31:0] cmd_reg;
  logic [15:0] cmd_op;
  logic [CH_W-1:0] cmd_idx;
  logic        cmd_bad;
  logic        cmd_is_wait;

  // Per-channel control
  logic [NUM_CH-1:0][31:0] offset;
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH-1:0]       force_tx;
  logic [NUM_CH-1:0]       wrap;
  logic [NUM_CH-1:0]       rst_mask;
  logic                    mask_sent, mask_ack, mask_err;
  logic                    err_flag;
  logic                    st_oom, st_axi, st_bad;
  logic [4:0]              wait_cnt;
  logic [CH_W-1:0]         last_grant;

  // Unpacked views of the per-channel input buses
  logic [NUM_CH-1:0][31:0]      lo_a, hi_a;
  logic [NUM_CH-1:0][LVL_W-1:0] lvl_a;
  assign lo_a  = in_ddr_low;
  assign hi_a  = in_ddr_high;
  assign lvl_a = in_level;

  // Requests and round-robin pick
  logic [NUM_CH-1:0] req;
  logic              rr_found;
  logic [CH_W-1:0]   rr_ch;
  int                rr_sum;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req[i] = enable[i] &
               ((32'(lvl_a[i]) >= 32'(BURST_MAX)) | (force_tx[i] & (lvl_a[i] != '0)));
    end
  end

  // Search starts one past the last grant and wraps, so a channel is only
  // granted twice in a row when it is the sole requester.
  always_comb begin
    rr_found = 1'b0;
    rr_ch    = '0;
    rr_sum   = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      rr_sum = int'(last_grant) + k;
      if (rr_sum >= NUM_CH) rr_sum = rr_sum - NUM_CH;
      if (!rr_found && req[CH_W'(rr_sum)]) begin
        rr_found = 1'b1;
        rr_ch    = CH_W'(rr_sum);
      end
    end
  end

  // Burst sizing for the granted channel
  logic [31:0] g_base, g_room, g_lvl32, g_len;

  always_comb begin
    g_base  = lo_a[out_axi_ch] + offset[out_axi_ch];
    // A window already consumed (high <= low+offset) leaves no room at all.
    g_room  = (hi_a[out_axi_ch] > g_base) ? ((hi_a[out_axi_ch] - g_base) >> 2) : 32'd0;
    g_lvl32 = 32'(lvl_a[out_axi_ch]);
    g_len   = g_lvl32;
    if (g_len > 32'(BURST_MAX)) g_len = 32'(BURST_MAX);
    if (g_len > g_room)         g_len = g_room;
  end

  // Command decode
  assign cmd_op      = cmd_reg[15:0];
  assign cmd_idx     = cmd_reg[28 +: CH_W];
  assign cmd_bad     = (32'(cmd_reg[31:28]) >= 32'(NUM_CH));
  assign cmd_is_wait = (cmd_op == 16'h0001) || (cmd_op == 16'h0002) || (cmd_op == 16'h0004);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      state_prev <= S_IDLE;
    end else begin
      state      <= state_next;
      state_prev <= state;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (cmd_pending)                      state_next = S_ACK;
        else if (in_axi_error || err_flag)    state_next = S_ERROR;
        else if (in_transfer_en && (|req))    state_next = S_ARB;
      end
      S_ACK:   state_next = S_EXEC;
      S_EXEC:  state_next = (!cmd_bad && cmd_is_wait) ? S_WAIT : S_IDLE;
      S_WAIT:  if (wait_cnt == 5'd0) state_next = S_IDLE;
      // A request can vanish between IDLE and ARB; fall back to IDLE then.
      S_ARB:   state_next = rr_found ? S_CALC : S_IDLE;
      S_CALC: begin
        if (g_room == 32'd0)     state_next = wrap[out_axi_ch] ? S_CALC : S_ERROR;
        else if (g_len == 32'd0) state_next = S_IDLE;
        else                     state_next = S_START;
      end
      S_START: state_next = S_WAIT_TX;
      S_WAIT_TX: begin
        if (in_axi_error)     state_next = S_ERROR;
        else if (in_axi_done) state_next = S_INTR;
      end
      S_INTR:  state_next = S_IDLE;
      S_ERROR: begin
        if (cmd_pending)                     state_next = S_ACK;
        else if (!in_axi_error && !err_flag) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath / control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_pending  <= 1'b0;
      cmd_reg      <= '0;
      offset       <= '0;
      enable       <= '0;
      force_tx     <= '0;
      wrap         <= '0;
      rst_mask     <= '0;
      mask_sent    <= 1'b0;
      mask_ack     <= 1'b0;
      mask_err     <= 1'b0;
      err_flag     <= 1'b0;
      st_oom       <= 1'b0;
      st_axi       <= 1'b0;
      st_bad       <= 1'b0;
      wait_cnt     <= '0;
      last_grant   <= CH_W'(NUM_CH - 1);
      out_axi_ch   <= '0;
      out_axi_addr <= '0;
      out_axi_len  <= '0;
    end else begin
      if (in_cmd_en && !cmd_pending) begin
        cmd_pending <= 1'b1;
        cmd_reg     <= in_cmd_data;
      end

      case (state)
        S_ACK: cmd_pending <= 1'b0;

        S_EXEC: begin
          rst_mask <= '0;
          wait_cnt <= 5'(RESET_WAIT);
          if (cmd_bad) begin
            st_bad <= 1'b1;
          end else begin
            case (cmd_op)
              16'h0001: begin
                offset     <= '0;
                enable     <= '0;
                force_tx   <= '0;
                wrap       <= '0;
                mask_sent  <= 1'b0;
                mask_ack   <= 1'b0;
                mask_err   <= 1'b0;
                err_flag   <= 1'b0;
                st_oom     <= 1'b0;
                st_axi     <= 1'b0;
                st_bad     <= 1'b0;
                last_grant <= CH_W'(NUM_CH - 1);
                rst_mask   <= '1;
              end
              16'h0002: offset[cmd_idx] <= '0;
              16'h0004: begin
                rst_mask          <= NUM_CH'(1) << cmd_idx;
                force_tx[cmd_idx] <= 1'b0;
              end
              16'h0020, 16'h0021: enable[cmd_idx] <= cmd_op[0];
              16'h0101:           force_tx[cmd_idx] <= 1'b1;
              16'h0040, 16'h0041: wrap[cmd_idx] <= cmd_op[0];
              16'h1010, 16'h1011: mask_sent <= cmd_op[0];
              16'h1080, 16'h1081: mask_ack  <= cmd_op[0];
              16'h1040, 16'h1041: mask_err  <= cmd_op[0];
              default: ;
            endcase
          end
        end

        S_WAIT: if (wait_cnt != 5'd0) wait_cnt <= wait_cnt - 5'd1;

        S_ARB: begin
          if (rr_found) begin
            out_axi_ch <= rr_ch;
            last_grant <= rr_ch;
          end
        end

        S_CALC: begin
          if (g_room == 32'd0) begin
            if (wrap[out_axi_ch]) begin
              offset[out_axi_ch] <= '0;
            end else begin
              st_oom   <= 1'b1;
              err_flag <= 1'b1;
            end
          end else begin
            out_axi_addr <= g_base;
            out_axi_len  <= g_len[8:0];
          end
        end

        S_WAIT_TX: begin
          if (in_axi_error) begin
            st_axi <= 1'b1;
          end else if (in_axi_done) begin
            offset[out_axi_ch] <= offset[out_axi_ch] + {21'b0, out_axi_len, 2'b00};
            // Keep force while data remains so the next round finishes it.
            if (g_lvl32 == 32'(out_axi_len)) force_tx[out_axi_ch] <= 1'b0;
          end
        end

        S_ERROR: st_axi <= in_axi_error;

        default: ;
      endcase
    end
  end

  // Moore outputs
  assign out_state         = state;
  assign out_axi_init      = (state == S_START);
  assign out_busy          = (state == S_ARB) || (state == S_CALC) || (state == S_START) ||
                             (state == S_WAIT_TX) || (state == S_INTR);
  assign out_enable        = enable;
  assign out_rst_data      = ((state == S_WAIT) && (state_prev != S_WAIT)) ? rst_mask : '0;
  assign out_cmd_processed = cmd_reg;
  assign out_status        = {st_bad, 5'b00000, st_axi, st_oom};
  assign intr_ack          = (state == S_ACK) && mask_ack;
  assign intr_sent         = (state == S_INTR) && mask_sent;
  assign intr_error        = (state == S_ERROR) && (state_prev != S_ERROR) && mask_err;

endmodule
